// File: rtl/uart_frame_rx_if.sv
// Receive-side consumer bus: head-of-FIFO frame fields plus valid/ready handshake.
interface uart_frame_rx_if;
    logic [7:0] rxData;
    logic       rxParityError;
    logic       rxFramingError;
    logic       rxBreak;
    logic       rxValid;
    logic       rxReady;

    modport master (
        output rxData,
        output rxParityError,
        output rxFramingError,
        output rxBreak,
        output rxValid,
        input  rxReady
    );

    modport slave (
        input  rxData,
        input  rxParityError,
        input  rxFramingError,
        input  rxBreak,
        input  rxValid,
        output rxReady
    );
endinterface

// File: rtl/uart_frame_rx.sv
// UART frame receiver: 5..8 data bits, optional parity, 1 or 2 stop bits,
// per-frame error flags queued in a small FIFO behind a valid/ready handshake.
module uart_frame_rx #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    input  logic [1:0]  dataBits,
    input  logic        hasParity,
    input  logic [1:0]  parityMode,
    input  logic        extraStopBit,
    input  logic [23:0] clockDivisor,
    output logic        overflow,
    input  logic        overflowClear,
    output logic        busy,
    uart_frame_rx_if.master rxIf
);

    localparam int unsigned DIV_W = 24;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP1, STOP2, FINISH, BREAK_WAIT
    } rxState_t;

    typedef struct packed {
        logic       brk;
        logic       framingErr;
        logic       parityErr;
        logic [7:0] data;
    } rxEntry_t;

    // rx synchronizer; resets to the idle-high line level so no false start follows reset
    logic [SYNC_STAGES-1:0] syncReg;
    logic                   rxs;
    logic                   rxsPrev;

    always_ff @(posedge clk) begin
        if (rst) begin
            syncReg <= '1;
            rxsPrev <= 1'b1;
        end else begin
            syncReg <= {syncReg[SYNC_STAGES-2:0], rx};
            rxsPrev <= rxs;
        end
    end

    assign rxs = syncReg[SYNC_STAGES-1];

    rxState_t         state;
    logic [DIV_W-1:0] bitCnt;
    logic [DIV_W-1:0] divLat;
    logic [DIV_W-1:0] halfLat;
    logic [2:0]       lastIdx;
    logic             parLat;
    logic [1:0]       modeLat;
    logic             stop2Lat;
    logic [2:0]       bitIdx;
    logic [7:0]       dataReg;
    logic             parSample;
    logic             parityErr;
    logic             framingErr;
    logic             sampleNow;
    logic             frameBreak;

    assign sampleNow  = (bitCnt == halfLat);
    assign frameBreak = (dataReg == 8'd0) && !parSample && framingErr;

    // Frame FSM; config is captured at start detect and held for the whole frame
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            bitCnt     <= '0;
            divLat     <= '0;
            halfLat    <= '0;
            lastIdx    <= '0;
            parLat     <= 1'b0;
            modeLat    <= '0;
            stop2Lat   <= 1'b0;
            bitIdx     <= '0;
            dataReg    <= '0;
            parSample  <= 1'b0;
            parityErr  <= 1'b0;
            framingErr <= 1'b0;
        end else begin
            if (state != IDLE && state != BREAK_WAIT) begin
                bitCnt <= (bitCnt == divLat - DIV_W'(1)) ? '0 : bitCnt + DIV_W'(1);
            end
            case (state)
                IDLE: begin
                    if (rxsPrev && !rxs) begin
                        state      <= START;
                        busy       <= 1'b1;
                        bitCnt     <= '0;
                        divLat     <= clockDivisor;
                        halfLat    <= clockDivisor >> 1;
                        lastIdx    <= 3'(dataBits) + 3'd4;
                        parLat     <= hasParity;
                        modeLat    <= parityMode;
                        stop2Lat   <= extraStopBit;
                        bitIdx     <= '0;
                        dataReg    <= '0;
                        parSample  <= 1'b0;
                        parityErr  <= 1'b0;
                        framingErr <= 1'b0;
                    end
                end
                START: begin
                    if (sampleNow) begin
                        if (rxs) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (sampleNow) begin
                        dataReg[bitIdx] <= rxs;
                        if (bitIdx == lastIdx) begin
                            state <= parLat ? PARITY : STOP1;
                        end else begin
                            bitIdx <= bitIdx + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    if (sampleNow) begin
                        parSample <= rxs;
                        case (modeLat)
                            2'b00:   parityErr <= rxs;
                            2'b11:   parityErr <= ~rxs;
                            2'b01:   parityErr <= (^dataReg) ^ rxs;
                            default: parityErr <= ~((^dataReg) ^ rxs);
                        endcase
                        state <= STOP1;
                    end
                end
                STOP1: begin
                    if (sampleNow) begin
                        framingErr <= ~rxs;
                        state      <= stop2Lat ? STOP2 : FINISH;
                    end
                end
                STOP2: begin
                    if (sampleNow) begin
                        framingErr <= framingErr | ~rxs;
                        state      <= FINISH;
                    end
                end
                FINISH: begin
                    state <= frameBreak ? BREAK_WAIT : IDLE;
                    busy  <= frameBreak;
                end
                BREAK_WAIT: begin
                    if (rxs) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    rxEntry_t         mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] rdNext;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] countNext;
    logic             pushReq;
    logic             popNow;
    logic             doPush;
    logic             doDrop;
    rxEntry_t         newEntry;
    rxEntry_t         headNext;

    assign pushReq  = (state == FINISH);
    assign popNow   = rxIf.rxValid && rxIf.rxReady;
    assign doPush   = pushReq && ((count != CNT_W'(FIFO_DEPTH)) || popNow);
    assign doDrop   = pushReq && !doPush;
    assign newEntry = '{brk: frameBreak, framingErr: framingErr, parityErr: parityErr, data: dataReg};
    assign rdNext   = popNow ? rdPtr + PTR_W'(1) : rdPtr;

    always_comb begin
        countNext = count;
        if (doPush && !popNow) begin
            countNext = count + CNT_W'(1);
        end else if (!doPush && popNow) begin
            countNext = count - CNT_W'(1);
        end
    end

    // The head slot may be the one being written this cycle, so bypass the new entry
    assign headNext = (doPush && (rdNext == wrPtr)) ? newEntry : mem[rdNext];

    always_ff @(posedge clk) begin
        if (!rst && doPush) begin
            mem[wrPtr] <= newEntry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr               <= '0;
            rdPtr               <= '0;
            count               <= '0;
            rxIf.rxValid        <= 1'b0;
            rxIf.rxData         <= '0;
            rxIf.rxParityError  <= 1'b0;
            rxIf.rxFramingError <= 1'b0;
            rxIf.rxBreak        <= 1'b0;
            overflow            <= 1'b0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            rdPtr        <= rdNext;
            count        <= countNext;
            rxIf.rxValid <= (countNext != '0);
            if (countNext != '0) begin
                rxIf.rxData         <= headNext.data;
                rxIf.rxParityError  <= headNext.parityErr;
                rxIf.rxFramingError <= headNext.framingErr;
                rxIf.rxBreak        <= headNext.brk;
            end
            // A drop in the same cycle as a clear keeps the flag set
            if (doDrop) begin
                overflow <= 1'b1;
            end else if (overflowClear) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule
